// File: rtl/text_console_writer.sv
// Text console writer: turns an ASCII byte stream into a COLS x ROWS character buffer
// with cursor, control codes, clear and scroll. Scrolling is built when TEXT_CONSOLE_SCROLL_EN is defined.
module text_console_writer #(
    parameter int          COLS      = 40,
    parameter int          ROWS      = 30,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] rd_addr,
    output logic [7:0]  rd_data,
    output logic [5:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy,
    output logic        dirty
);

    localparam int          CELLS     = COLS * ROWS;
    localparam logic [10:0] LAST_CELL = 11'(CELLS - 1);
    localparam logic [10:0] LAST_COL  = 11'(COLS - 1);
    localparam logic [5:0]  COL_LAST  = 6'(COLS - 1);
    localparam logic [4:0]  ROW_LAST  = 5'(ROWS - 1);
`ifdef TEXT_CONSOLE_SCROLL_EN
    localparam logic [10:0] SCROLL_LAST = 11'((ROWS - 1) * COLS);
    localparam logic [10:0] FILL_BASE   = 11'((ROWS - 1) * COLS);
`else
    localparam logic [10:0] FILL_BASE   = 11'd0;
`endif

    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] FF = 8'h0C;
    localparam logic [7:0] CR = 8'h0D;

`ifdef TEXT_CONSOLE_SCROLL_EN
    typedef enum logic [1:0] {IDLE, CLEAR, SCROLL, FILL_ROW} state_t;
`else
    typedef enum logic [1:0] {IDLE, CLEAR, FILL_ROW} state_t;
`endif

    state_t      state;
    logic [10:0] op_cnt;
    logic [7:0]  mem [CELLS];

    logic        accept, is_print, col_last, row_last, adv_row;
    logic [10:0] cur_addr;
    logic        we;
    logic [10:0] waddr;
    logic [7:0]  wdata;
`ifdef TEXT_CONSOLE_SCROLL_EN
    logic [7:0]  scroll_q;
`endif

    assign in_ready = (state == IDLE) && rst_n;
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign is_print = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign col_last = (cursor_col == COL_LAST);
    assign row_last = (cursor_row == ROW_LAST);
    assign cur_addr = 11'(cursor_row) * 11'(COLS) + 11'(cursor_col);
    assign adv_row  = accept && ((is_print && col_last) || (in_data == LF));

    // Port B write controls, decoded from the current state and the accepted byte.
    always_comb begin
        // NOTE: every output gets a default first so no path can leave one unassigned and infer a latch.
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (accept && is_print) begin
                        we    = 1'b1;
                        waddr = cur_addr;
                        wdata = in_data;
                    end else if (accept && in_data == BS && cursor_col != '0) begin
                        we    = 1'b1;
                        waddr = cur_addr - 11'd1;
                        wdata = FILL_CHAR;
                    end
                end
                CLEAR: begin
                    we    = 1'b1;
                    waddr = op_cnt;
                    wdata = FILL_CHAR;
                end
`ifdef TEXT_CONSOLE_SCROLL_EN
                SCROLL: begin
                    // Write lags the read by one cycle, so cycle 0 only primes scroll_q.
                    if (op_cnt != '0) begin
                        we    = 1'b1;
                        waddr = op_cnt - 11'd1;
                        wdata = scroll_q;
                    end
                end
`endif
                FILL_ROW: begin
                    we    = 1'b1;
                    waddr = FILL_BASE + op_cnt;
                    wdata = FILL_CHAR;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the RAM array is deliberately not reset; CLEAR initialises it after every reset.
    always_ff @(posedge pclk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Renderer port: registered read, returns the pre-write value on a same-address collision.
    always_ff @(posedge pclk) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= (rd_addr < 11'(CELLS)) ? mem[rd_addr] : '0;
    end

`ifdef TEXT_CONSOLE_SCROLL_EN
    always_ff @(posedge pclk) begin
        if (state == SCROLL && op_cnt < SCROLL_LAST) scroll_q <= mem[op_cnt + 11'(COLS)];
    end
`endif

    // NOTE: all sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state      <= CLEAR;
            op_cnt     <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            dirty      <= 1'b0;
        end else begin
            dirty <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_print) begin
                            cursor_col <= col_last ? '0 : cursor_col + 6'd1;
                            // A char that triggers a wrap-around operation signals dirty when that finishes.
                            dirty      <= !(col_last && row_last);
                        end else begin
                            case (in_data)
                                LF, CR: cursor_col <= '0;
                                BS: begin
                                    if (cursor_col != '0) begin
                                        cursor_col <= cursor_col - 6'd1;
                                        dirty      <= 1'b1;
                                    end
                                end
                                FF: begin
                                    cursor_col <= '0;
                                    cursor_row <= '0;
                                    op_cnt     <= '0;
                                    state      <= CLEAR;
                                end
                                default: ;
                            endcase
                        end
                        if (adv_row) begin
                            if (!row_last) begin
                                cursor_row <= cursor_row + 5'd1;
                            end else begin
                                op_cnt <= '0;
`ifdef TEXT_CONSOLE_SCROLL_EN
                                state  <= SCROLL;
`else
                                cursor_row <= '0;
                                state      <= FILL_ROW;
`endif
                            end
                        end
                    end
                end
                CLEAR: begin
                    if (op_cnt == LAST_CELL) begin
                        op_cnt <= '0;
                        state  <= IDLE;
                        dirty  <= 1'b1;
                    end else begin
                        op_cnt <= op_cnt + 11'd1;
                    end
                end
`ifdef TEXT_CONSOLE_SCROLL_EN
                SCROLL: begin
                    if (op_cnt == SCROLL_LAST) begin
                        op_cnt <= '0;
                        state  <= FILL_ROW;
                    end else begin
                        op_cnt <= op_cnt + 11'd1;
                    end
                end
`endif
                FILL_ROW: begin
                    if (op_cnt == LAST_COL) begin
                        op_cnt <= '0;
                        state  <= IDLE;
                        dirty  <= 1'b1;
                    end else begin
                        op_cnt <= op_cnt + 11'd1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: vector table for single-byte behaviour plus
// sequences for clear, wrap/scroll and reset; a screen model supplies expected buffer contents.
module tb_text_console_writer;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;
`ifdef TEXT_CONSOLE_SCROLL_EN
    localparam int WRAP_CYCLES = (ROWS - 1) * COLS + 1 + COLS;
`else
    localparam int WRAP_CYCLES = COLS;
`endif

    logic        pclk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] rd_addr;
    logic [7:0]  rd_data;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;
    logic        dirty;

    text_console_writer dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy),
        .dirty      (dirty)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_mem [CELLS];
    int         exp_col;
    int         exp_row;

    typedef struct {
        logic [7:0] data;
        logic [5:0] col;
        logic [4:0] row;
        logic       dirty;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < CELLS; i++) exp_mem[i] = 8'h20;
        exp_col = 0;
        exp_row = 0;
    endtask

    task automatic model_adv_row();
        if (exp_row < ROWS - 1) begin
            exp_row++;
        end else begin
`ifdef TEXT_CONSOLE_SCROLL_EN
            for (int i = 0; i < (ROWS - 1) * COLS; i++) exp_mem[i] = exp_mem[i + COLS];
            for (int c = 0; c < COLS; c++) exp_mem[(ROWS - 1) * COLS + c] = 8'h20;
`else
            exp_row = 0;
            for (int c = 0; c < COLS; c++) exp_mem[c] = 8'h20;
`endif
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_mem[exp_row * COLS + exp_col] = b;
            if (exp_col < COLS - 1) exp_col++;
            else begin
                exp_col = 0;
                model_adv_row();
            end
        end else if (b == 8'h0A) begin
            exp_col = 0;
            model_adv_row();
        end else if (b == 8'h0D) begin
            exp_col = 0;
        end else if (b == 8'h08) begin
            if (exp_col > 0) begin
                exp_col--;
                exp_mem[exp_row * COLS + exp_col] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            model_clear();
        end
    endtask

    // Presents one byte for one edge; returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge pclk);
        in_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic wait_op(input string name, input int exp_cycles);
        int cycles     = 0;
        int dirty_seen = 0;
        while (busy && cycles < 5000) begin
            cycles++;
            if (dirty) dirty_seen++;
            @(negedge pclk);
        end
        // Drop any held byte before the first edge at which the writer could take it.
        in_valid = 1'b0;
        check({name, "_busy_cycles"}, 32'(cycles), 32'(exp_cycles));
        check({name, "_dirty_while_busy"}, 32'(dirty_seen), 32'd0);
        check({name, "_done_dirty"}, 32'(dirty), 32'd1);
        check({name, "_done_ready"}, 32'(in_ready), 32'd1);
        @(negedge pclk);
        check({name, "_dirty_one_cycle"}, 32'(dirty), 32'd0);
    endtask

    task automatic verify_screen(input string name);
        int bad = 0;
        for (int i = 0; i < CELLS; i++) begin
            rd_addr = 11'(i);
            @(negedge pclk);
            if (rd_data !== exp_mem[i]) bad++;
        end
        check({name, "_bad_cells"}, 32'(bad), 32'd0);
    endtask

    task automatic check_cursor(input string name);
        check({name, "_col"}, 32'(cursor_col), 32'(exp_col));
        check({name, "_row"}, 32'(cursor_row), 32'(exp_row));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{8'h0D, 6'd0, 5'd0, 1'b0};
        vecs[1]  = '{8'h43, 6'd1, 5'd0, 1'b1};
        vecs[2]  = '{8'h08, 6'd0, 5'd0, 1'b1};
        vecs[3]  = '{8'h08, 6'd0, 5'd0, 1'b0};
        vecs[4]  = '{8'h01, 6'd0, 5'd0, 1'b0};
        vecs[5]  = '{8'h7F, 6'd0, 5'd0, 1'b0};
        vecs[6]  = '{8'h7E, 6'd1, 5'd0, 1'b1};
        vecs[7]  = '{8'h0A, 6'd0, 5'd1, 1'b0};
        vecs[8]  = '{8'h20, 6'd1, 5'd1, 1'b1};
        vecs[9]  = '{8'h1F, 6'd1, 5'd1, 1'b0};
        vecs[10] = '{8'h0D, 6'd0, 5'd1, 1'b0};
        vecs[11] = '{8'h0A, 6'd0, 5'd2, 1'b0};

        rst_n    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        rd_addr  = '0;
        model_clear();

        repeat (2) @(negedge pclk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_dirty", 32'(dirty), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check_cursor("rst");
        rst_n = 1'b1;
        wait_op("init_clear", CELLS);
        verify_screen("init_clear");

        // "AB" back-to-back with in_valid held high.
        in_data  = 8'h41;
        in_valid = 1'b1;
        @(negedge pclk);
        check("ab_a_dirty", 32'(dirty), 32'd1);
        check("ab_a_col", 32'(cursor_col), 32'd1);
        in_data = 8'h42;
        @(negedge pclk);
        in_valid = 1'b0;
        check("ab_b_dirty", 32'(dirty), 32'd1);
        check("ab_b_col", 32'(cursor_col), 32'd2);
        model_byte(8'h41);
        model_byte(8'h42);
        rd_addr = 11'd0;
        @(negedge pclk);
        check("ab_dirty_off", 32'(dirty), 32'd0);
        check("ab_cell0", 32'(rd_data), 32'h41);
        rd_addr = 11'd1;
        @(negedge pclk);
        check("ab_cell1", 32'(rd_data), 32'h42);

        for (int i = 0; i < 12; i++) begin
            send_byte(vecs[i].data);
            check($sformatf("vec%0d_col", i), 32'(cursor_col), 32'(vecs[i].col));
            check($sformatf("vec%0d_row", i), 32'(cursor_row), 32'(vecs[i].row));
            check($sformatf("vec%0d_dirty", i), 32'(dirty), 32'(vecs[i].dirty));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
        end
        verify_screen("vectors");

        send_byte(8'h0C);
        check("ff_busy", 32'(busy), 32'd1);
        check_cursor("ff");
        wait_op("ff_clear", CELLS);
        verify_screen("ff_clear");

        // Backspace from column 5 blanks cell 4.
        send_byte(8'h68); send_byte(8'h65); send_byte(8'h6C); send_byte(8'h6C); send_byte(8'h6F);
        check("hello_col", 32'(cursor_col), 32'd5);
        send_byte(8'h08);
        check("bs5_col", 32'(cursor_col), 32'd4);
        check("bs5_dirty", 32'(dirty), 32'd1);
        rd_addr = 11'd4;
        @(negedge pclk);
        check("bs5_cell4", 32'(rd_data), 32'h20);

        // A full row of 'X' wraps to the next row without any busy period.
        send_byte(8'h0D);
        for (int c = 0; c < COLS; c++) send_byte(8'h58);
        check("row0_col", 32'(cursor_col), 32'd0);
        check("row0_row", 32'(cursor_row), 32'd1);
        check("row0_busy", 32'(busy), 32'd0);
        check("row0_dirty", 32'(dirty), 32'd1);
        verify_screen("row0_x");

        // Distinct char per row, stopping at the last column of the last row.
        for (int r = 1; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++) send_byte(8'(8'h61 + r));
        for (int c = 0; c < COLS - 1; c++) send_byte(8'h7E);
        check("full_col", 32'(cursor_col), 32'(COLS - 1));
        check("full_row", 32'(cursor_row), 32'(ROWS - 1));
        send_byte(8'h0A);
        wait_op("lf_wrap", WRAP_CYCLES);
`ifdef TEXT_CONSOLE_SCROLL_EN
        check("lf_wrap_row", 32'(cursor_row), 32'(ROWS - 1));
`else
        check("lf_wrap_row", 32'(cursor_row), 32'd0);
`endif
        check_cursor("lf_wrap");
        verify_screen("lf_wrap");

        // A printable char in the last cell is stored before the wrap operation runs.
        while (exp_row != ROWS - 1) send_byte(8'h0A);
        send_byte(8'h0D);
        for (int c = 0; c < COLS; c++) send_byte(8'h5A);
        wait_op("char_wrap", WRAP_CYCLES);
        check_cursor("char_wrap");
        verify_screen("char_wrap");

        // Reset in the middle of the wrap operation, with a byte held on the input throughout.
        while (exp_row != ROWS - 1) send_byte(8'h0A);
        in_data  = 8'h0A;
        in_valid = 1'b1;
        @(negedge pclk);
        model_byte(8'h0A);
        in_data = 8'h51;
        repeat (20) @(negedge pclk);
        check("mid_busy", 32'(busy), 32'd1);
        check_cursor("mid_hold");
        rst_n = 1'b0;
        @(negedge pclk);
        model_clear();
        check("mid_rst_busy", 32'(busy), 32'd1);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_dirty", 32'(dirty), 32'd0);
        check_cursor("mid_rst");
        rst_n = 1'b1;
        wait_op("mid_rst_clear", CELLS);
        check_cursor("mid_rst_done");
        verify_screen("mid_rst_clear");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
